// File: rtl/tex_spi_arbiter.sv
// rtl/tex_spi_arbiter.sv - two-requester arbiter and single-bit SPI READ sequencer for the texture flash
//
// Purpose:
//   Shares one external texture SPI flash between requester 0 (current-column
//   texel fetch) and requester 1 (background/preload fetch). Each transaction
//   is a standard READ: command 0x03, 24-bit address, then DATA_BITS data bits,
//   followed by CSB_GAP clk cycles with CSB high before the next grant.
//
// Configuration macro:
//   TEXSPI_RR_ARB_EN - defined: round-robin between requesters on a tie
//                      (pointer resets to "last granted = 1").
//                      undefined: fixed priority, requester 0 always wins.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   i_req0/i_addr0        - requester 0 level request and 24-bit address
//   o_done0               - one-cycle pulse, o_data valid for requester 0
//   i_req1/i_addr1        - requester 1 level request and 24-bit address
//   o_done1               - one-cycle pulse, o_data valid for requester 1
//   o_data                - last word read, MSB first as received
//   o_busy                - high from grant edge until return to IDLE
//   o_grant               - requester owning the current/last transaction
//   o_tex_csb/o_tex_sclk  - flash chip select (active low) and SPI clock (clk/2)
//   o_tex_out0/o_tex_oeb0 - IO0 output data and output enable (active low)
//   i_tex_in              - MISO from the flash

module tex_spi_arbiter #(
    parameter int DATA_BITS = 6,
    parameter int CSB_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req0,
    input  logic [23:0]          i_addr0,
    output logic                 o_done0,
    input  logic                 i_req1,
    input  logic [23:0]          i_addr1,
    output logic                 o_done1,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_busy,
    output logic                 o_grant,
    output logic                 o_tex_csb,
    output logic                 o_tex_sclk,
    output logic                 o_tex_out0,
    output logic                 o_tex_oeb0,
    input  logic                 i_tex_in
);

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);
    // The IDLE cycle before the next grant is itself one of the CSB-high
    // cycles, so the GAP state only covers the remaining CSB_GAP-1 cycles.
    localparam int GAP_W    = (CSB_GAP > 2) ? $clog2(CSB_GAP - 1) : 1;
    localparam int GAP_LOAD = (CSB_GAP >= 2) ? (CSB_GAP - 2) : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [31:0]          tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic                 busy_q, busy_d;
    logic                 grant_q, grant_d;
    logic                 csb_q, csb_d;
    logic                 sclk_q, sclk_d;
    logic                 out0_q, out0_d;
    logic                 oeb0_q, oeb0_d;
    logic                 sel;
    logic [DATA_BITS:0]   rx_shift;

`ifdef TEXSPI_RR_ARB_EN
    logic rr_last_q, rr_last_d;

    always_comb begin
        rr_last_d = rr_last_q;
        if (i_req0 && i_req1) begin
            sel = ~rr_last_q;
        end else begin
            sel = ~i_req0;
        end
        if (state_q == S_IDLE && (i_req0 || i_req1)) begin
            rr_last_d = sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        sel = ~i_req0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        gap_cnt_d = gap_cnt_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = busy_q;
        grant_d   = grant_q;
        csb_d     = csb_q;
        sclk_d    = sclk_q;
        out0_d    = out0_q;
        oeb0_d    = oeb0_q;
        rx_shift  = {rx_q, i_tex_in};

        case (state_q)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    grant_d   = sel;
                    // out0 presents the command MSB now; tx_q holds everything after it.
                    out0_d    = CMD_READ[7];
                    tx_d      = {CMD_READ[6:0], (sel ? i_addr1 : i_addr0), 1'b0};
                    csb_d     = 1'b0;
                    oeb0_d    = 1'b0;
                    sclk_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = 5'd0;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d    = 1'b0;
                    out0_d    = tx_q[31];
                    tx_d      = tx_q << 1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        // Release IO0 to the flash for the data phase.
                        bit_cnt_d = 5'd0;
                        out0_d    = 1'b0;
                        oeb0_d    = 1'b1;
                        state_d   = S_DATA;
                    end else begin
                        out0_d = tx_q[31];
                        tx_d   = tx_q << 1;
                    end
                end
            end
            S_DATA: begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // Sample MISO on the edge that ends the high phase.
                    sclk_d    = 1'b0;
                    rx_d      = rx_shift[DATA_BITS-1:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == DATA_LAST) begin
                        csb_d     = 1'b1;
                        data_d    = rx_shift[DATA_BITS-1:0];
                        done0_d   = ~grant_q;
                        done1_d   = grant_q;
                        gap_cnt_d = GAP_W'(GAP_LOAD);
                        if (CSB_GAP >= 2) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
                out0_d  = 1'b0;
                oeb0_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 5'd0;
            tx_q      <= 32'd0;
            rx_q      <= '0;
            data_q    <= '0;
            gap_cnt_q <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            csb_q     <= 1'b1;
            sclk_q    <= 1'b0;
            out0_q    <= 1'b0;
            oeb0_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            gap_cnt_q <= gap_cnt_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            csb_q     <= csb_d;
            sclk_q    <= sclk_d;
            out0_q    <= out0_d;
            oeb0_q    <= oeb0_d;
        end
    end

    assign o_done0    = done0_q;
    assign o_done1    = done1_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_grant    = grant_q;
    assign o_tex_csb  = csb_q;
    assign o_tex_sclk = sclk_q;
    assign o_tex_out0 = out0_q;
    assign o_tex_oeb0 = oeb0_q;

endmodule

// File: doc/tex_spi_arbiter.md
Name: tex_spi_arbiter

Overview:
- Shares the single external texture SPI flash between two read requesters: req0 is the texel fetch for the current column; req1 is the background/preload fetch.
- Sequences each read as a standard single-bit SPI READ: command 0x03, then a 24-bit address, then DATA_BITS data bits.
- Drives the rbzero texture SPI pins o_tex_csb, o_tex_sclk, o_tex_out0 and o_tex_oeb0, and samples i_tex_in.
- Returns the assembled word to the granted requester with a one-cycle done pulse.

Parameters:
- DATA_BITS, 6, bits read per transaction (RGB222 texel); legal range 1..32.
- CSB_GAP, 2, clk cycles CSB is held high between transactions; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_req0  in  1  request from requester 0, level-sensitive.
- i_addr0  in  24  read address for requester 0.
- o_done0  out  1  one-cycle pulse; o_data is valid for requester 0.
- i_req1  in  1  request from requester 1, level-sensitive.
- i_addr1  in  24  read address for requester 1.
- o_done1  out  1  one-cycle pulse; o_data is valid for requester 1.
- o_data  out  DATA_BITS  last word read, MSB first as received.
- o_busy  out  1  high from the grant edge until the return to IDLE.
- o_grant  out  1  requester owning the current or last transaction (0/1).
- o_tex_csb  out  1  flash chip select, active low.
- o_tex_sclk  out  1  SPI clock; runs at clk/2 while CSB is low.
- o_tex_out0  out  1  MOSI (IO0) output data.
- o_tex_oeb0  out  1  IO0 output enable, active low.
- i_tex_in  in  1  MISO from the flash.

Behaviour:
- Reset (async) values: csb=1, sclk=0, out0=0, oeb0=1, done0=done1=0, o_data=0, busy=0, grant=0, state=IDLE.
- Reset asserted mid-transaction: CSB goes high immediately; no done pulse follows.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (DATA_BITS bits) -> GAP (CSB_GAP cycles) -> IDLE.
- Arbitration in IDLE, fixed priority: req0 beats req1. Requests are sampled only in IDLE.
- Grant edge E0: latch the selected address and grant; set csb=0, oeb0=0, busy=1; out0 = command bit 7.
- Each bit takes 2 clk cycles:
  - Low phase: sclk=0, out0 holds the bit.
  - Edge E(2i+1): sclk becomes 1.
  - Edge E(2i+2): sclk returns to 0 and out0 advances to the next bit.
- Bit order: command then address, MSB first.
- oeb0=0 through CMD and ADDR. From the edge that starts the first DATA bit, oeb0=1 and out0=0.
- DATA bits: i_tex_in is shifted in (MSB first) on the edge that ends each high phase (sclk 1->0).
- Last data bit ends at edge E(2*(32+DATA_BITS)); E76 with defaults. On that edge:
  - csb=1, sclk=0;
  - o_data takes the full shifted word;
  - done for the granted requester is high for exactly one cycle.
- GAP lasts CSB_GAP cycles, counted from that edge. busy drops on entry to IDLE.
- Request-to-done latency: 2*(32+DATA_BITS) cycles after the grant edge.
- Requester contract:
  - Hold req and addr until done.
  - Changes to the granted address after E0 are ignored.
  - If req is dropped mid-transaction, the transaction still completes and still pulses done.
  - If req is still high when IDLE is re-entered, it is a new request.
- The non-granted requester waits with req held; its request is never lost.
- o_data holds its value between transactions.
- done0 and done1 are never high together.

Optional Feature:
- Macro TEXSPI_RR_ARB_EN.
- Defined: round-robin arbitration. When both requests are pending in IDLE, the grant goes to the requester not granted last. With a single requester pending, that requester is granted. The round-robin pointer resets to "last granted = 1", so req0 wins the first tie.
- Undefined: fixed priority, req0 always wins.

Test Plan:
- Single read: req0=1, addr0=0x123456, i_tex_in driven 1,0,1,1,0,1 on the data bits.
  - out0 sampled at each sclk rise gives 0x03 then 0x123456.
  - done0 pulses 76 cycles after grant; o_data=6'b101101.
  - oeb0 is 0 only during the 32 CMD/ADDR bits.
- Simultaneous requests: req0 (addr 0x000100) and req1 (addr 0x000200) high together.
  - req0 is served first.
  - After the CSB_GAP=2 high cycles, req1 is served with addr 0x000200; done1 follows done0 by 78 cycles.
- Late request: req1 raised mid-transaction of req0 → held, granted on the first IDLE cycle, no loss.
- Reset mid-operation: assert reset 30 cycles after grant.
  - csb=1, oeb0=1, sclk=0 before the next clk edge.
  - No done pulse follows; after release, the pending req0 starts a clean transaction.
- With TEXSPI_RR_ARB_EN: both requests held continuously → grants alternate 0,1,0,1. Without the macro → grant stays 0 every time.
- Requester drops req0 at cycle 10 → transaction still completes; done0 pulses at cycle 76; no new transaction starts.
